iwdg_cfg_sequencer: RTL
=======================

Name: iwdg_cfg_sequencer

Overview:
Wishbone master that configures and services the IWDG slave on the same bus.
- On a start pulse it runs the unlock/prescaler/reload/status-poll/enable key sequence.
- It then keeps the watchdog refreshed, either on software kick requests or from an internal auto-kick timer.
- It sits between system control logic and the IWDG register port.
- It removes hand-sequenced key writes from software and test benches.

Parameters:
BASE_ADR, 32'h0100_0000, IWDG base address
IWDG_KR_ADR, BASE_ADR + 32'h0, key register address
IWDG_PR_ADR, BASE_ADR + 32'h4, prescaler register address
IWDG_RLR_ADR, BASE_ADR + 32'h8, reload register address
IWDG_ST_ADR, BASE_ADR + 32'hC, status register address
KICK_PERIOD, 1000, clk_m2s cycles between automatic refreshes (must be >= 2)
ACK_TIMEOUT, 64, cycles with cyc_m2s high and no ack before bus error
POLL_LIMIT, 256, maximum status reads before poll error

Ports:
clk_m2s  in  1  system/bus clock, the only clock
rst_m2s  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse: begin configuration (honoured only in IDLE)
pr_cfg  in  3  prescaler value, sampled on the start cycle
rlr_cfg  in  12  reload value, sampled on the start cycle
auto_kick_en  in  1  enables the internal refresh timer while RUN
kick_req  in  1  one-cycle pulse: request a refresh
adr_m2s  out  32  Wishbone address
dat_m2s  out  16  Wishbone write data
we_m2s  out  1  Wishbone write enable
cyc_m2s  out  1  Wishbone cycle
stb_m2s  out  1  Wishbone strobe
dat_s2m  in  16  Wishbone read data
ack_s2m  in  1  Wishbone acknowledge
busy  out  1  high in any state except IDLE, RUN, ERROR
running  out  1  high in RUN and WR_KICK
err  out  1  sticky error flag
err_code  out  2  00 none, 01 ack timeout, 10 status poll limit

Behaviour:
- Interface: one clock (clk_m2s); reset rst_m2s is synchronous and active-high.
- All outputs are registered.
- Reset values: cyc_m2s, stb_m2s, we_m2s = 0; adr_m2s = 0; dat_m2s = 0; busy, running, err = 0; err_code = 00.
- Reset mid-transaction drops cyc_m2s/stb_m2s at that edge and forces IDLE. Latched config, kick pending flag, timers and poll counter are all cleared.
- Bus cycle, applied in every bus state:
  - On the edge entering the state, drive adr/dat/we and set cyc=stb=1.
  - Hold all of them stable until ack_s2m is sampled high.
  - On the ack edge, clear cyc/stb; we may stay.
  - Every transaction is followed by at least one idle cycle with cyc=0.
- Timeout: an internal counter increments while cyc=1 and ack=0. At ACK_TIMEOUT it clears cyc/stb and the FSM goes to ERROR with err_code=01.
- FSM states and transitions:
  - IDLE: on start, latch pr_cfg/rlr_cfg and go to WR_UNLOCK.
  - WR_UNLOCK: write 16'h5555 to KR, then WR_PR.
  - WR_PR: write {13'b0, pr} to PR, then WR_RLR.
  - WR_RLR: write {4'b0, rlr} to RLR, then RD_ST.
  - RD_ST: read ST with we=0.
    - On ack with dat_s2m[1:0]==0, go to WR_START.
    - Otherwise increment the poll count, wait one idle cycle, and re-read.
    - When the POLL_LIMIT-th read completes non-zero, go to ERROR with err_code=10.
  - WR_START: write 16'hCCCC to KR, then RUN, and load the auto timer with KICK_PERIOD.
  - RUN: decrement the auto timer each cycle when auto_kick_en=1 (timer holds when 0).
    - Go to WR_KICK when kick_req=1, a kick is pending, or the timer reaches 0 with auto_kick_en=1.
    - The timer reloads to KICK_PERIOD on every completed kick.
  - WR_KICK: write 16'hAAAA to KR, clear the pending flag, then RUN.
  - ERROR: cyc=stb=0; stays until reset.
- Boundary rules:
  - kick_req while in WR_KICK sets a one-deep pending flag. Multiple requests coalesce into one extra kick.
  - kick_req while not in RUN/WR_KICK is ignored.
  - start outside IDLE is ignored, including RUN; a started watchdog cannot be stopped.
  - kick_req and timer expiry in the same cycle produce one kick.
  - err is set on the same edge as entry to ERROR.

Test Plan:
- Reset 10 cycles, then start with pr_cfg=3'b001, rlr_cfg=12'h001, slave acking in 1 cycle and ST=0. Required: exactly KR<-5555, PR<-0001, RLR<-0001, one ST read, KR<-CCCC, in that order with one idle cycle between each; running=1; busy=0.
- ST returns 2'b01 for 3 reads, then 0. Required: 4 ST reads, then KR<-CCCC; err=0.
- ST stuck at 2'b10 with POLL_LIMIT=4. Required: exactly 4 reads, err=1, err_code=10, no CCCC write.
- In RUN with auto_kick_en=1 and KICK_PERIOD=20. Required: KR<-AAAA every 20 cycles plus the bus latency. kick_req pulses twice during an in-flight kick produce exactly one extra AAAA.
- Slave never acks on the PR write with ACK_TIMEOUT=8. Required: cyc drops after 8 cycles; err=1, err_code=01; a later start is ignored.
- rst_m2s asserted while cyc=1 during the RLR write. Required: cyc/stb=0 at that edge, all outputs at reset values; a new start reruns the full sequence from 5555.

Source files
------------

// File: rtl/iwdg_cfg_sequencer.sv
// Wishbone master: runs the IWDG unlock/prescaler/reload/status-poll/enable sequence, then refreshes it.
// Latency: one bus access per register write/read, each followed by one idle cycle; all outputs registered.
// Backpressure: every access holds adr/dat/we/cyc/stb until ack_s2m; ACK_TIMEOUT cycles without ack -> ERROR.
module iwdg_cfg_sequencer #(
    parameter logic [31:0] BASE_ADR    = 32'h0100_0000,
    parameter logic [31:0] IWDG_KR_ADR  = BASE_ADR + 32'h0,
    parameter logic [31:0] IWDG_PR_ADR  = BASE_ADR + 32'h4,
    parameter logic [31:0] IWDG_RLR_ADR = BASE_ADR + 32'h8,
    parameter logic [31:0] IWDG_ST_ADR  = BASE_ADR + 32'hC,
    parameter int          KICK_PERIOD  = 1000,
    parameter int          ACK_TIMEOUT  = 64,
    parameter int          POLL_LIMIT   = 256
) (
    input  logic        clk_m2s,
    input  logic        rst_m2s,
    input  logic        start,
    input  logic [2:0]  pr_cfg,
    input  logic [11:0] rlr_cfg,
    input  logic        auto_kick_en,
    input  logic        kick_req,
    output logic [31:0] adr_m2s,
    output logic [15:0] dat_m2s,
    output logic        we_m2s,
    output logic        cyc_m2s,
    output logic        stb_m2s,
    input  logic [15:0] dat_s2m,
    input  logic        ack_s2m,
    output logic        busy,
    output logic        running,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int TMW = $clog2(KICK_PERIOD + 1);
    localparam int TOW = $clog2(ACK_TIMEOUT + 1);
    localparam int PLW = $clog2(POLL_LIMIT + 1);
    localparam logic [TMW-1:0] TMR_LOAD  = TMW'(KICK_PERIOD);
    localparam logic [TMW-1:0] TMR_ONE   = TMW'(1);
    localparam logic [TOW-1:0] TO_LAST   = TOW'(ACK_TIMEOUT - 1);
    localparam logic [TOW-1:0] TO_ONE    = TOW'(1);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_LIMIT - 1);
    localparam logic [PLW-1:0] POLL_ONE  = PLW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_UNLOCK,
        S_WR_PR,
        S_WR_RLR,
        S_RD_ST,
        S_WR_START,
        S_RUN,
        S_WR_KICK,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [15:0]     dat_q, dat_d;
    logic            gap_q, gap_d;      // access acked, spending the mandatory idle cycle
    logic            rty_q, rty_d;      // status read was non-zero, re-read after the idle cycle
    logic [TOW-1:0]  to_q, to_d;
    logic [PLW-1:0]  poll_q, poll_d;
    logic [TMW-1:0]  tmr_q, tmr_d;
    logic            pend_q, pend_d;
    logic [2:0]      pr_q, pr_d;
    logic [11:0]     rlr_q, rlr_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            busy_q, busy_d, run_q, run_d;

    logic            iss, iss_we;
    logic [31:0]     iss_adr;
    logic [15:0]     iss_dat;
    logic            acked, st_clear, expire;
    logic            unused_st;

    // Only the two status bits matter; upper read data is ignored.
    assign unused_st = ^dat_s2m[15:2];

    // Next-state, bus-cycle and bookkeeping logic; outputs are computed here and registered below.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        gap_d   = gap_q;
        rty_d   = rty_q;
        to_d    = to_q;
        poll_d  = poll_q;
        tmr_d   = tmr_q;
        pend_d  = pend_q;
        pr_d    = pr_q;
        rlr_d   = rlr_q;
        err_d   = err_q;
        code_d  = code_q;
        iss     = 1'b0;
        iss_we  = 1'b0;
        iss_adr = 32'h0;
        iss_dat = 16'h0;
        expire  = 1'b0;
        acked    = cyc_q && ack_s2m;
        st_clear = (dat_s2m[1:0] == 2'b00);

        // The ack edge always ends the access; per-state code decides what follows.
        if (acked) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pr_d    = pr_cfg;
                    rlr_d   = rlr_cfg;
                    poll_d  = '0;
                    pend_d  = 1'b0;
                    state_d = S_WR_UNLOCK;
                    iss     = 1'b1;
                    iss_we  = 1'b1;
                    iss_adr = IWDG_KR_ADR;
                    iss_dat = 16'h5555;
                end
            end
            S_WR_UNLOCK: begin
                if (acked) begin
                    gap_d = 1'b1;
                end else if (gap_q) begin
                    state_d = S_WR_PR;
                    iss     = 1'b1;
                    iss_we  = 1'b1;
                    iss_adr = IWDG_PR_ADR;
                    iss_dat = {13'h0, pr_q};
                end
            end
            S_WR_PR: begin
                if (acked) begin
                    gap_d = 1'b1;
                end else if (gap_q) begin
                    state_d = S_WR_RLR;
                    iss     = 1'b1;
                    iss_we  = 1'b1;
                    iss_adr = IWDG_RLR_ADR;
                    iss_dat = {4'h0, rlr_q};
                end
            end
            S_WR_RLR: begin
                if (acked) begin
                    gap_d = 1'b1;
                end else if (gap_q) begin
                    state_d = S_RD_ST;
                    iss     = 1'b1;
                    iss_adr = IWDG_ST_ADR;
                end
            end
            S_RD_ST: begin
                if (acked) begin
                    if (st_clear) begin
                        gap_d = 1'b1;
                    end else if (poll_q == POLL_LAST) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                    end else begin
                        poll_d = poll_q + POLL_ONE;
                        rty_d  = 1'b1;
                    end
                end else if (gap_q) begin
                    state_d = S_WR_START;
                    iss     = 1'b1;
                    iss_we  = 1'b1;
                    iss_adr = IWDG_KR_ADR;
                    iss_dat = 16'hCCCC;
                end else if (rty_q) begin
                    iss     = 1'b1;
                    iss_adr = IWDG_ST_ADR;
                end
            end
            S_WR_START: begin
                if (acked) begin
                    gap_d = 1'b1;
                end else if (gap_q) begin
                    gap_d   = 1'b0;
                    tmr_d   = TMR_LOAD;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (auto_kick_en && (tmr_q != '0)) begin
                    tmr_d = tmr_q - TMR_ONE;
                end
                // Timer at 1 reaches 0 on this edge; a simultaneous kick_req still gives one kick.
                expire = auto_kick_en && (tmr_q <= TMR_ONE);
                if (kick_req || pend_q || expire) begin
                    pend_d  = 1'b0;
                    state_d = S_WR_KICK;
                    iss     = 1'b1;
                    iss_we  = 1'b1;
                    iss_adr = IWDG_KR_ADR;
                    iss_dat = 16'hAAAA;
                end
            end
            S_WR_KICK: begin
                // Requests during an in-flight kick coalesce into one extra kick.
                if (kick_req) begin
                    pend_d = 1'b1;
                end
                if (acked) begin
                    gap_d = 1'b1;
                end else if (gap_q) begin
                    gap_d   = 1'b0;
                    tmr_d   = TMR_LOAD;
                    state_d = S_RUN;
                end
            end
            S_ERROR: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (iss) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = iss_we;
            adr_d = iss_adr;
            dat_d = iss_dat;
            to_d  = '0;
            gap_d = 1'b0;
            rty_d = 1'b0;
        end

        // A stalled slave aborts the access and parks the sequencer in ERROR.
        if (cyc_q && !ack_s2m) begin
            if (to_q == TO_LAST) begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = S_ERROR;
                err_d   = 1'b1;
                code_d  = 2'b01;
            end else begin
                to_d = to_q + TO_ONE;
            end
        end

        busy_d = !((state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_ERROR));
        run_d  = (state_d == S_RUN) || (state_d == S_WR_KICK);
    end

    // State and registered outputs; reset drops any in-flight access immediately.
    always_ff @(posedge clk_m2s) begin
        if (rst_m2s) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 16'h0;
            gap_q   <= 1'b0;
            rty_q   <= 1'b0;
            to_q    <= '0;
            poll_q  <= '0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            pr_q    <= 3'h0;
            rlr_q   <= 12'h0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            gap_q   <= gap_d;
            rty_q   <= rty_d;
            to_q    <= to_d;
            poll_q  <= poll_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            pr_q    <= pr_d;
            rlr_q   <= rlr_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            run_q   <= run_d;
        end
    end

    assign adr_m2s  = adr_q;
    assign dat_m2s  = dat_q;
    assign we_m2s   = we_q;
    assign cyc_m2s  = cyc_q;
    assign stb_m2s  = stb_q;
    assign busy     = busy_q;
    assign running  = run_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule
